// File: rtl/demux_1_to_16_router_pkg.sv
// demux_1_to_16_router_pkg: channel count, select/occupancy widths and helpers shared by router and read mux
package demux_1_to_16_router_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W = 4;
  localparam int OCC_W = 5;
  typedef logic [SEL_W-1:0] ch_idx_t;
  function automatic logic [OCC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_CH; i++) popcount = popcount + OCC_W'(v[i]);
  endfunction
endpackage

// File: rtl/demux_1_to_16_router_if.sv
// demux_1_to_16_router_if: source-side stream plus the 16 per-channel output handshakes
interface demux_1_to_16_router_if
  import demux_1_to_16_router_pkg::*;
#(parameter int N = 8);
  logic in_valid;
  logic in_ready;
  ch_idx_t in_sel;
  logic in_bcast;
  logic [N-1:0] in_data;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [NUM_CH*N-1:0] out_data;
  logic [OCC_W-1:0] occupied;
  modport master(
    output in_valid, in_sel, in_bcast, in_data, out_ready,
    input in_ready, out_valid, out_data, occupied
  );
  modport slave(
    input in_valid, in_sel, in_bcast, in_data, out_ready,
    output in_ready, out_valid, out_data, occupied
  );
endinterface

// File: rtl/demux_1_to_16_router_slot.sv
// router_slot: one-entry holding register; a load wins over a same-cycle drain
module router_slot #(parameter int N = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [N-1:0] i_load_data,
  input  logic         i_out_ready,
  output logic         o_out_valid,
  output logic [N-1:0] o_out_data
);
  logic         r_valid;
  logic [N-1:0] r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;
endmodule

// File: rtl/demux_1_to_16_router.sv
// demux_1_to_16_router: routes one stream to 16 independently stalling channels, with broadcast
module demux_1_to_16_router
  import demux_1_to_16_router_pkg::*;
#(parameter int N = 8) (
  input  logic clk,
  input  logic rst_n,
  demux_1_to_16_router_if.slave bus
);
  logic [NUM_CH-1:0] w_free;
  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_valid;
  logic [NUM_CH-1:0] w_next_valid;
  logic              w_accept;
  logic [N-1:0]      w_data [NUM_CH];
  logic [OCC_W-1:0]  r_occupied;
  assign w_free       = ~w_valid | bus.out_ready;
  assign bus.in_ready = bus.in_bcast ? &w_free : w_free[bus.in_sel];
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_load       = !w_accept ? '0 : bus.in_bcast ? '1 : NUM_CH'(1) << bus.in_sel;
  // occupied is registered from the next-state valid so it tracks out_valid cycle for cycle
  assign w_next_valid = w_load | (w_valid & ~bus.out_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occupied <= '0;
    else r_occupied <= popcount(w_next_valid);
  end
  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    router_slot #(.N(N)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load[g]),
      .i_load_data (bus.in_data),
      .i_out_ready (bus.out_ready[g]),
      .o_out_valid (w_valid[g]),
      .o_out_data  (w_data[g])
    );
  end
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < NUM_CH; i++) bus.out_data[i*N +: N] = w_data[i];
  end
  assign bus.out_valid = w_valid;
  assign bus.occupied  = r_occupied;
endmodule

// File: tb/tb_demux_1_to_16_router.sv
// tb_demux_1_to_16_router: directed cases plus random soak against per-channel word queues
module tb_demux_1_to_16_router;
  import demux_1_to_16_router_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux_1_to_16_router_if #(.N(N)) bus();
  demux_1_to_16_router #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0;
  int checks = 0;
  logic [N-1:0] q [NUM_CH][$];
  logic [N-1:0] last [NUM_CH];
  bit last_acc;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] exp_valid();
    for (int i = 0; i < NUM_CH; i++) exp_valid[i] = q[i].size() != 0;
  endfunction
  function automatic logic [127:0] exp_data();
    for (int i = 0; i < NUM_CH; i++) exp_data[i*N +: N] = last[i];
  endfunction
  function automatic bit exp_ready();
    bit all = 1;
    for (int i = 0; i < NUM_CH; i++) all &= (q[i].size() == 0) || bus.out_ready[i];
    return bus.in_bcast ? all : (q[bus.in_sel].size() == 0) || bus.out_ready[bus.in_sel];
  endfunction
  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      q[i].delete();
      last[i] = '0;
    end
  endtask
  task automatic tick();
    bit rdy;
    #1;
    rdy = exp_ready();
    check("in_ready", 128'(bus.in_ready), 128'(rdy));
    for (int i = 0; i < NUM_CH; i++)
      if (q[i].size() != 0 && bus.out_ready[i]) check($sformatf("drain%0d", i), 128'(bus.out_data[i*N +: N]), 128'(q[i].pop_front()));
    last_acc = bus.in_valid && rdy;
    if (last_acc)
      for (int i = 0; i < NUM_CH; i++)
        if (bus.in_bcast || int'(bus.in_sel) == i) begin
          q[i].push_back(bus.in_data);
          last[i] = bus.in_data;
        end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", 128'(bus.out_valid), 128'(exp_valid()));
    check("out_data", bus.out_data, exp_data());
    check("occupied", 128'(bus.occupied), 128'($countones(exp_valid())));
  endtask
  task automatic drive(input bit v, input bit b, input int s, input logic [7:0] d, input logic [15:0] r);
    bus.in_valid = v;
    bus.in_bcast = b;
    bus.in_sel = ch_idx_t'(s);
    bus.in_data = d;
    bus.out_ready = r;
  endtask
  task automatic do_reset();
    drive(0, 0, 0, 8'h00, 16'h0000);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 128'(bus.out_valid), 128'h0);
    check("rst_occ", 128'(bus.occupied), 128'h0);
    check("rst_data", bus.out_data, 128'h0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    model_clear();
    drive(0, 0, 0, 8'h00, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 3, 8'h11, 16'h0000); tick();
    drive(1, 0, 9, 8'h22, 16'h0000); tick();
    check("pre_rst_valid", 128'(bus.out_valid), 128'h0208);
    #2;
    do_reset();
    drive(1, 0, 3, 8'h33, 16'h0000); tick();
    check("post_rst_valid", 128'(bus.out_valid), 128'h0008);
    do_reset();
    drive(1, 0, 5, 8'hA5, 16'h0000); tick();
    check("uni_valid", 128'(bus.out_valid), 128'h0020);
    check("uni_data5", 128'(bus.out_data[5*N +: N]), 128'hA5);
    check("uni_occ", 128'(bus.occupied), 128'd1);
    drive(1, 0, 5, 8'h5A, 16'h0000);
    #1 check("stall_rdy", 128'(bus.in_ready), 128'h0);
    tick();
    check("stall_data5", 128'(bus.out_data[5*N +: N]), 128'hA5);
    drive(1, 0, 6, 8'h66, 16'h0000);
    #1 check("ch6_rdy", 128'(bus.in_ready), 128'h1);
    tick();
    check("ch6_valid", 128'(bus.out_valid), 128'h0060);
    do_reset();
    drive(1, 0, 2, 8'h00, 16'h0000); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(1, 0, 2, 8'(k), 16'h0004);
      #1 check("thru_rdy", 128'(bus.in_ready), 128'h1);
      tick();
      check("thru_data2", 128'(bus.out_data[2*N +: N]), 128'(k));
      check("thru_valid2", 128'(bus.out_valid[2]), 128'h1);
    end
    do_reset();
    drive(1, 0, 15, 8'hF0, 16'h0000); tick();
    drive(1, 1, 0, 8'h3C, 16'h0000);
    #1 check("bc_blocked", 128'(bus.in_ready), 128'h0);
    tick();
    drive(1, 1, 0, 8'h3C, 16'h8000); tick();
    drive(0, 0, 0, 8'h00, 16'h0000);
    check("bc_valid", 128'(bus.out_valid), 128'hFFFF);
    check("bc_occ", 128'(bus.occupied), 128'd16);
    check("bc_data", bus.out_data, {16{8'h3C}});
    drive(0, 0, 0, 8'h00, 16'h0101); tick();
    check("drain_valid", 128'(bus.out_valid), 128'hFEFE);
    check("drain_occ", 128'(bus.occupied), 128'd14);
    check("drain_data", bus.out_data, {16{8'h3C}});
    begin
      bit pend = 0;
      repeat (10000) begin
        if (!pend) begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_bcast = $urandom_range(0, 15) == 0;
          bus.in_sel = ch_idx_t'($urandom_range(0, 15));
          bus.in_data = 8'($urandom);
        end
        bus.out_ready = 16'($urandom);
        tick();
        pend = bus.in_valid && !last_acc;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
